// File: rtl/bus_datapath_pkg.sv
// Shared encodings for the bus datapath and the control unit that drives it:
// Bus 1 / Bus 2 driver selects and the DR1/DR2 source selects.
package bus_datapath_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   localparam logic [2:0] SEL_R1   = 3'b000;
   localparam logic [2:0] SEL_R2   = 3'b001;
   localparam logic [2:0] SEL_R3   = 3'b010;
   localparam logic [2:0] SEL_AC   = 3'b011;
   localparam logic [2:0] SEL_OUTR = 3'b100;

   localparam logic SEL_B_ZERO = 1'b0;
   localparam logic SEL_B_R2   = 1'b1;

   localparam logic DR1_SRC_BUS1 = 1'b0;
   localparam logic DR1_SRC_BUS2 = 1'b1;
   localparam logic DR2_SRC_BUS2 = 1'b0;
   localparam logic DR2_SRC_BUS1 = 1'b1;

   // Codes above SEL_OUTR have no driver and leave Bus 1 at zero.
   function automatic logic sel_a_valid(input logic [2:0] sel);
      return sel <= SEL_OUTR;
   endfunction

endpackage

// File: rtl/bus_datapath_alu.sv
// bus_alu: combinational WIDTH+1-bit adder of DR1 and DR2, with carry-out
// and a zero flag on the truncated WIDTH-bit sum.
module bus_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] full_sum;

   always_comb begin
      full_sum = {1'b0, a} + {1'b0, b};
      sum      = full_sum[WIDTH-1:0];
      carry    = full_sum[WIDTH];
      zero     = (full_sum[WIDTH-1:0] == '0);
   end

endmodule

// File: rtl/bus_datapath.sv
// Two-bus register-transfer datapath (R1..R3, DR1, DR2, AC, OUTR, adder ALU).
// Optional BUS_CONFLICT_CHECK_EN adds a sticky bus_err for loads from an undriven Bus 1.
module bus_datapath
   import bus_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_load,
   input  logic [WIDTH-1:0] init_r1,
   input  logic [WIDTH-1:0] init_r2,
   input  logic [WIDTH-1:0] init_r3,
   input  logic [2:0]       sel_A,
   input  logic             sel_B,
   input  logic             LD_R1,
   input  logic             LD_R2,
   input  logic             LD_R3,
   input  logic             LD_DR1,
   input  logic             LD_DR2,
   input  logic             LD_AC,
   input  logic             LD_outr,
   input  logic             sel_DR1,
   input  logic             sel_DR2,
   output logic [WIDTH-1:0] bus1,
   output logic [WIDTH-1:0] bus2,
   output logic [WIDTH-1:0] outr,
   output logic [WIDTH-1:0] ac,
   output logic             carry,
   output logic             zero
`ifdef BUS_CONFLICT_CHECK_EN
   ,
   output logic             bus_err
`endif
);

   logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
   logic [WIDTH-1:0] dr1_q, dr1_d, dr2_q, dr2_d;
   logic [WIDTH-1:0] ac_q, ac_d, outr_q, outr_d;
   logic             carry_q, carry_d, zero_q, zero_d;
   logic [WIDTH-1:0] alu_sum;
   logic             alu_carry, alu_zero;

   bus_alu #(.WIDTH(WIDTH)) u_alu (
      .a     (dr1_q),
      .b     (dr2_q),
      .sum   (alu_sum),
      .carry (alu_carry),
      .zero  (alu_zero)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      bus1 = '0;
      case (sel_A)
         SEL_R1:   bus1 = r1_q;
         SEL_R2:   bus1 = r2_q;
         SEL_R3:   bus1 = r3_q;
         SEL_AC:   bus1 = ac_q;
         SEL_OUTR: bus1 = outr_q;
         default:  bus1 = '0;
      endcase
      bus2 = (sel_B == SEL_B_R2) ? r2_q : '0;
   end

   // All sources are pre-edge values, so any mix of loads in one cycle is a true transfer.
   always_comb begin
      r1_d    = r1_q;
      r2_d    = r2_q;
      r3_d    = r3_q;
      dr1_d   = dr1_q;
      dr2_d   = dr2_q;
      ac_d    = ac_q;
      outr_d  = outr_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      if (init_load) begin
         r1_d = init_r1;
         r2_d = init_r2;
         r3_d = init_r3;
      end else begin
         if (LD_R1)   r1_d   = bus1;
         if (LD_R2)   r2_d   = bus1;
         if (LD_R3)   r3_d   = bus1;
         if (LD_outr) outr_d = bus1;
         if (LD_DR1)  dr1_d  = (sel_DR1 == DR1_SRC_BUS2) ? bus2 : bus1;
         if (LD_DR2)  dr2_d  = (sel_DR2 == DR2_SRC_BUS1) ? bus1 : bus2;
         if (LD_AC) begin
            ac_d    = alu_sum;
            carry_d = alu_carry;
            zero_d  = alu_zero;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_q    <= '0;
         r2_q    <= '0;
         r3_q    <= '0;
         dr1_q   <= '0;
         dr2_q   <= '0;
         ac_q    <= '0;
         outr_q  <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         r3_q    <= r3_d;
         dr1_q   <= dr1_d;
         dr2_q   <= dr2_d;
         ac_q    <= ac_d;
         outr_q  <= outr_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign outr  = outr_q;
   assign ac    = ac_q;
   assign carry = carry_q;
   assign zero  = zero_q;

`ifdef BUS_CONFLICT_CHECK_EN
   logic bus_err_q, bus_err_d;
   logic bus1_load;

   always_comb begin
      bus1_load = LD_R1 | LD_R2 | LD_R3 | LD_outr
                | (LD_DR1 & (sel_DR1 == DR1_SRC_BUS1))
                | (LD_DR2 & (sel_DR2 == DR2_SRC_BUS1));
      bus_err_d = bus_err_q | (~init_load & bus1_load & ~sel_a_valid(sel_A));
   end

   always_ff @(posedge clk) begin
      if (rst) bus_err_q <= 1'b0;
      else     bus_err_q <= bus_err_d;
   end

   assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: stimulus pushes expected output values,
// a negedge monitor pops and compares them. Define BUS_CONFLICT_CHECK_EN to cover bus_err.
module tb_bus_datapath;
   import bus_datapath_pkg::*;

   localparam int W = 8;

   typedef enum {O_BUS1, O_BUS2, O_AC, O_OUTR, O_CARRY, O_ZERO, O_ERR} obs_e;
   typedef struct {
      obs_e        o;
      logic [W-1:0] v;
      string       name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, init_load;
   logic [W-1:0] init_r1, init_r2, init_r3;
   logic [2:0]   sel_A;
   logic         sel_B, sel_DR1, sel_DR2;
   logic         LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr;
   logic [W-1:0] bus1, bus2, outr, ac;
   logic         carry, zero;
`ifdef BUS_CONFLICT_CHECK_EN
   logic         bus_err;
`endif

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   bus_datapath #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .init_load(init_load),
      .init_r1(init_r1), .init_r2(init_r2), .init_r3(init_r3),
      .sel_A(sel_A), .sel_B(sel_B),
      .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3), .LD_DR1(LD_DR1),
      .LD_DR2(LD_DR2), .LD_AC(LD_AC), .LD_outr(LD_outr),
      .sel_DR1(sel_DR1), .sel_DR2(sel_DR2),
      .bus1(bus1), .bus2(bus2), .outr(outr), .ac(ac),
      .carry(carry), .zero(zero)
`ifdef BUS_CONFLICT_CHECK_EN
      , .bus_err(bus_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic logic [W-1:0] observe(input obs_e o);
      logic [W-1:0] r;
      r = '0;
      case (o)
         O_BUS1:  r = bus1;
         O_BUS2:  r = bus2;
         O_AC:    r = ac;
         O_OUTR:  r = outr;
         O_CARRY: r = {{(W-1){1'b0}}, carry};
         O_ZERO:  r = {{(W-1){1'b0}}, zero};
`ifdef BUS_CONFLICT_CHECK_EN
         O_ERR:   r = {{(W-1){1'b0}}, bus_err};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // Monitor: everything expected for the current cycle is compared mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, observe(e.o), e.v);
         end
      end
   end

   task automatic expect_val(input obs_e o, input logic [W-1:0] v, input string name);
      exp_t e;
      e.o = o; e.v = v; e.name = name;
      exp_q.push_back(e);
   endtask

   // Advance one edge, then drop all strobes; selects keep their values.
   task automatic step();
      @(posedge clk);
      #1;
      rst = 0; init_load = 0;
      {LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr} = '0;
   endtask

   task automatic do_init(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      init_load = 1; init_r1 = a; init_r2 = b; init_r3 = c;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; init_load = 0; init_r1 = '0; init_r2 = '0; init_r3 = '0;
      sel_A = SEL_R1; sel_B = SEL_B_ZERO; sel_DR1 = 0; sel_DR2 = 0;
      {LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr} = '0;
      step();

      // Reset state
      expect_val(O_AC, 0, "rst_ac");      expect_val(O_CARRY, 0, "rst_carry");
      expect_val(O_ZERO, 1, "rst_zero");  expect_val(O_OUTR, 0, "rst_outr");
      expect_val(O_BUS1, 0, "rst_r1");    expect_val(O_BUS2, 0, "rst_bus2");
`ifdef BUS_CONFLICT_CHECK_EN
      expect_val(O_ERR, 0, "rst_err");
`endif
      step();

      // T0..T3 / E sequence
      do_init(3, 5, 0); step();
      sel_A = SEL_R1; sel_B = SEL_B_R2; LD_DR1 = 1; LD_DR2 = 1;
      expect_val(O_BUS1, 3, "t0_bus1"); expect_val(O_BUS2, 5, "t0_bus2"); step();
      sel_A = SEL_R2; LD_R1 = 1; LD_AC = 1;
      expect_val(O_BUS1, 5, "t1_bus1"); step();
      sel_A = SEL_AC; LD_R3 = 1;
      expect_val(O_BUS1, 8, "t2_bus1_ac"); expect_val(O_AC, 8, "t1_ac");
      expect_val(O_CARRY, 0, "t1_carry");  expect_val(O_ZERO, 0, "t1_zero"); step();
      sel_A = SEL_R3; LD_R2 = 1;
      expect_val(O_BUS1, 8, "t3_bus1_r3"); step();
      sel_A = SEL_R3; LD_outr = 1;
      expect_val(O_BUS2, 8, "e_bus2_r2"); step();
      sel_A = SEL_R1;
      expect_val(O_OUTR, 8, "e_outr"); expect_val(O_BUS1, 5, "e_r1"); expect_val(O_AC, 8, "e_ac"); step();
      sel_A = SEL_OUTR;
      expect_val(O_BUS1, 8, "e_bus1_outr"); step();

      // Overflow and wrap to zero
      do_init(200, 100, 0); step();
      sel_A = SEL_R1; sel_B = SEL_B_R2; sel_DR1 = DR1_SRC_BUS1; sel_DR2 = DR2_SRC_BUS2;
      LD_DR1 = 1; LD_DR2 = 1; step();
      LD_AC = 1; step();
      expect_val(O_AC, 44, "ovf_ac"); expect_val(O_CARRY, 1, "ovf_carry"); expect_val(O_ZERO, 0, "ovf_zero");
      do_init(128, 128, 0); step();
      LD_DR1 = 1; LD_DR2 = 1; step();
      LD_AC = 1; step();
      expect_val(O_AC, 0, "wrap_ac"); expect_val(O_CARRY, 1, "wrap_carry"); expect_val(O_ZERO, 1, "wrap_zero"); step();
      expect_val(O_CARRY, 1, "hold_carry"); expect_val(O_ZERO, 1, "hold_zero"); step();

      // Same-edge swap through the cross-bus DR sources
      do_init(7, 9, 0); step();
      sel_A = SEL_R1; sel_B = SEL_B_R2; sel_DR1 = DR1_SRC_BUS2; sel_DR2 = DR2_SRC_BUS1;
      LD_DR1 = 1; LD_DR2 = 1; step();
      sel_A = SEL_R2; LD_R1 = 1; LD_AC = 1;
      expect_val(O_BUS1, 9, "swap_bus1"); step();
      expect_val(O_AC, 16, "swap_sum");
      sel_A = SEL_R1; sel_B = SEL_B_ZERO; sel_DR2 = DR2_SRC_BUS2; LD_DR2 = 1;
      expect_val(O_BUS1, 9, "swap_r1"); step();
      LD_AC = 1; step();
      sel_A = SEL_R2;
      expect_val(O_AC, 9, "swap_dr1"); expect_val(O_BUS1, 9, "swap_r2"); step();

      // init_load beats LD_R1, rst beats everything
      do_init(11, 22, 33); sel_A = SEL_AC; LD_R1 = 1; step();
      sel_A = SEL_R1;
      expect_val(O_BUS1, 11, "prio_r1"); step();
      rst = 1; sel_A = SEL_R2; LD_R1 = 1; LD_AC = 1; step();
      sel_A = SEL_R1;
      expect_val(O_AC, 0, "mrst_ac");   expect_val(O_CARRY, 0, "mrst_carry");
      expect_val(O_ZERO, 1, "mrst_zero"); expect_val(O_OUTR, 0, "mrst_outr");
      expect_val(O_BUS1, 0, "mrst_r1"); step();
      sel_A = SEL_R2; expect_val(O_BUS1, 0, "mrst_r2"); step();
      sel_A = SEL_R3; expect_val(O_BUS1, 0, "mrst_r3"); step();

      // Invalid Bus 1 select
      do_init(1, 2, 3); step();
      sel_A = SEL_R3;
      expect_val(O_BUS1, 3, "inv_pre_r3");
`ifdef BUS_CONFLICT_CHECK_EN
      expect_val(O_ERR, 0, "inv_pre_err");
`endif
      step();
      sel_A = 3'b110; LD_R3 = 1;
      expect_val(O_BUS1, 0, "inv_bus1"); step();
      sel_A = SEL_R3;
      expect_val(O_BUS1, 0, "inv_r3");
`ifdef BUS_CONFLICT_CHECK_EN
      expect_val(O_ERR, 1, "inv_err_set");
`endif
      step();
      sel_A = 3'b111;
      expect_val(O_BUS1, 0, "inv_bus1_111");
`ifdef BUS_CONFLICT_CHECK_EN
      expect_val(O_ERR, 1, "inv_err_sticky");
`endif
      step();
      sel_A = SEL_R1; rst = 1; step();
`ifdef BUS_CONFLICT_CHECK_EN
      expect_val(O_ERR, 0, "inv_err_clr");
`endif
      expect_val(O_ZERO, 1, "end_zero");
      step();

      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
